// File: rtl/ifu_fetch.sv
// Instruction fetch unit: owns the PC, issues one imem request at a time and hands {inst, pc} to decode.
// Optional misaligned-redirect trap enabled by defining IFU_MISALIGN_CHECK_EN.
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        fetch_misalign
);

  typedef enum logic [1:0] {REQ, WAIT, HOLD} state_t;

  state_t      state, state_next;
  logic [31:0] pc, pc_next;
  logic [31:0] inst_next, inst_pc_next;
  logic        kill, kill_next;
  logic        misalign, misalign_next;
  logic [31:0] redirect_target;
  logic        redirect_bad;
  logic        accepted;

`ifdef IFU_MISALIGN_CHECK_EN
  assign redirect_target = redirect_pc;
  assign redirect_bad    = (redirect_pc[1:0] != 2'b00);
`else
  // Low bits are discarded; the AND keeps them formally consumed.
  assign redirect_target = {redirect_pc[31:2], 2'b00};
  assign redirect_bad    = 1'b0 & (|redirect_pc[1:0]);
`endif

  assign imem_req_valid = (state == REQ) && !misalign && !rst;
  assign imem_req_addr  = pc;
  assign inst_valid     = (state == HOLD);
  assign fetch_misalign = misalign;
  assign accepted       = imem_req_valid && imem_req_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= REQ;
      pc       <= RESET_PC;
      kill     <= 1'b0;
      misalign <= 1'b0;
      inst     <= 32'h0;
      inst_pc  <= 32'h0;
    end else begin
      state    <= state_next;
      pc       <= pc_next;
      kill     <= kill_next;
      misalign <= misalign_next;
      inst     <= inst_next;
      inst_pc  <= inst_pc_next;
    end
  end

  always_comb begin
    state_next    = state;
    pc_next       = pc;
    kill_next     = kill;
    misalign_next = misalign;
    inst_next     = inst;
    inst_pc_next  = inst_pc;

    case (state)
      REQ: begin
        if (accepted) state_next = WAIT;
      end
      WAIT: begin
        if (imem_rsp_valid) begin
          if (kill) begin
            kill_next  = 1'b0;
            state_next = REQ;
          end else begin
            inst_next    = imem_rsp_data;
            inst_pc_next = pc;
            state_next   = HOLD;
          end
        end
      end
      HOLD: begin
        if (inst_ready) begin
          pc_next    = pc + 32'd4;
          state_next = REQ;
        end
      end
      default: state_next = REQ;
    endcase

    // Redirect overrides everything decided above.
    if (redirect_valid) begin
      pc_next       = redirect_target;
      misalign_next = redirect_bad;
      inst_next     = inst;
      inst_pc_next  = inst_pc;
      case (state)
        REQ: begin
          if (accepted) begin
            state_next = WAIT;
            kill_next  = 1'b1;
          end else begin
            state_next = REQ;
          end
        end
        WAIT: begin
          // The in-flight response must still drain before a new request may go out.
          if (imem_rsp_valid) begin
            state_next = REQ;
            kill_next  = 1'b0;
          end else begin
            state_next = WAIT;
            kill_next  = 1'b1;
          end
        end
        default: state_next = REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_ifu_fetch.sv
// Self-checking bench for ifu_fetch: directed scenarios then randomized traffic against a transaction-level model.
module tb_ifu_fetch;
  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fetch_misalign;

  ifu_fetch #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .fetch_misalign(fetch_misalign)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: next fetch address, one outstanding memory transaction, one held instruction.
  logic [31:0] m_pc;
  bit          m_out, m_killed, m_hold, m_stall;
  logic [31:0] m_out_addr, m_out_data, m_hold_inst, m_hold_pc;
  int          m_delay;
  int          consumed = 0;
  bit          fixed_en = 1'b0;
  logic [31:0] fixed_data = 32'h0;
  int          delay_min = 0;
  int          delay_max = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc     = RESET_PC;
    m_out    = 1'b0;
    m_killed = 1'b0;
    m_hold   = 1'b0;
    m_stall  = 1'b0;
    m_delay  = 0;
  endtask

  function automatic logic [31:0] target_of(input logic [31:0] p);
`ifdef IFU_MISALIGN_CHECK_EN
    return p;
`else
    return {p[31:2], 2'b00};
`endif
  endfunction

  function automatic bit misaligned(input logic [31:0] p);
`ifdef IFU_MISALIGN_CHECK_EN
    return (p[1:0] != 2'b00);
`else
    return 1'b0;
`endif
  endfunction

  // One clock cycle: check outputs at the falling edge, drive inputs, advance the model.
  task automatic step(input bit rq_rdy, input bit in_rdy, input bit redir,
                      input logic [31:0] rpc, input bit spurious);
    bit exp_req, accept, rsp;
    @(negedge clk);
    exp_req = !m_out && !m_hold && !m_stall;
    check_eq("req_valid", {31'b0, imem_req_valid}, {31'b0, exp_req});
    if (exp_req) check_eq("req_addr", imem_req_addr, m_pc);
    check_eq("inst_valid", {31'b0, inst_valid}, {31'b0, m_hold});
    if (m_hold) begin
      check_eq("inst", inst, m_hold_inst);
      check_eq("inst_pc", inst_pc, m_hold_pc);
    end
    check_eq("fetch_misalign", {31'b0, fetch_misalign}, {31'b0, m_stall});

    rsp            = m_out && (m_delay == 0);
    imem_req_ready = rq_rdy;
    inst_ready     = in_rdy;
    redirect_valid = redir;
    redirect_pc    = rpc;
    imem_rsp_valid = rsp || (spurious && !m_out);
    imem_rsp_data  = rsp ? m_out_data : $urandom;
    accept         = exp_req && rq_rdy;

    if (m_hold && in_rdy) begin
      consumed++;
      $display("tb: consumed pc=%h inst=%h", m_hold_pc, m_hold_inst);
      m_hold = 1'b0;
      if (!redir) m_pc = m_pc + 32'd4;
    end
    if (m_hold && redir) m_hold = 1'b0;
    if (rsp) begin
      m_out = 1'b0;
      if (!m_killed && !redir) begin
        m_hold      = 1'b1;
        m_hold_inst = m_out_data;
        m_hold_pc   = m_out_addr;
      end
    end else if (m_out) begin
      m_delay--;
    end
    if (accept) begin
      m_out      = 1'b1;
      m_killed   = redir;
      m_out_addr = m_pc;
      m_out_data = fixed_en ? fixed_data : $urandom;
      m_delay    = $urandom_range(delay_max, delay_min);
    end
    if (redir) begin
      if (m_out) m_killed = 1'b1;
      m_pc    = target_of(rpc);
      m_stall = misaligned(rpc);
    end
  endtask

  initial begin
    logic [31:0] rpc;
    rst            = 1'b1;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    inst_ready     = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    model_reset();

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_req_valid", {31'b0, imem_req_valid}, 32'h0);
    check_eq("rst_req_addr", imem_req_addr, RESET_PC);
    check_eq("rst_inst_valid", {31'b0, inst_valid}, 32'h0);
    check_eq("rst_inst", inst, 32'h0);
    check_eq("rst_inst_pc", inst_pc, 32'h0);
    check_eq("rst_misalign", {31'b0, fetch_misalign}, 32'h0);
    rst = 1'b0;

    // Back-to-back fetches with zero memory latency: 3 instructions in 9 cycles.
    fixed_en   = 1'b1;
    fixed_data = 32'h0050_0093;
    repeat (9) step(1, 1, 0, 32'h0, 0);
    check_eq("three_in_nine", consumed, 32'd3);
    @(posedge clk); #1;
    check_eq("seq_next_addr", imem_req_addr, 32'h8000_000C);

    // Decode stalls for 5 cycles in HOLD.
    fixed_data = 32'h1234_5678;
    step(1, 0, 0, 32'h0, 0);
    step(1, 0, 0, 32'h0, 0);
    repeat (5) step(1, 0, 0, 32'h0, 1);
    step(1, 1, 0, 32'h0, 0);
    @(posedge clk); #1;
    check_eq("after_stall_addr", imem_req_addr, 32'h8000_0010);

    // Redirect while waiting on memory: the response is dropped.
    fixed_data = 32'hDEAD_BEEF;
    delay_min  = 2;
    delay_max  = 2;
    step(1, 1, 0, 32'h0, 0);
    step(0, 1, 1, 32'h8000_0100, 0);
    step(0, 1, 0, 32'h0, 0);
    step(0, 1, 0, 32'h0, 0);
    @(posedge clk); #1;
    check_eq("redir_addr", imem_req_addr, 32'h8000_0100);
    check_eq("redir_no_inst", {31'b0, inst_valid}, 32'h0);

    // Top-of-memory wrap.
    delay_min = 0;
    delay_max = 0;
    step(0, 1, 1, 32'hFFFF_FFFC, 0);
    step(1, 1, 0, 32'h0, 0);
    step(1, 1, 0, 32'h0, 0);
    step(0, 1, 0, 32'h0, 0);
    @(posedge clk); #1;
    check_eq("wrap_addr", imem_req_addr, 32'h0000_0000);

    // Misaligned redirect.
    step(0, 1, 1, 32'h8000_0102, 0);
    @(posedge clk); #1;
`ifdef IFU_MISALIGN_CHECK_EN
    check_eq("misalign_flag", {31'b0, fetch_misalign}, 32'h1);
    check_eq("misalign_no_req", {31'b0, imem_req_valid}, 32'h0);
    step(0, 1, 1, 32'h8000_0100, 0);
`else
    check_eq("misalign_addr", imem_req_addr, 32'h8000_0100);
    check_eq("misalign_flag", {31'b0, fetch_misalign}, 32'h0);
`endif

    // Asynchronous reset in the middle of a memory wait.
    delay_min = 3;
    delay_max = 3;
    step(1, 1, 0, 32'h0, 0);
    step(0, 1, 0, 32'h0, 0);
    #2 rst = 1'b1;
    imem_rsp_valid = 1'b0;
    #1;
    check_eq("arst_req_valid", {31'b0, imem_req_valid}, 32'h0);
    check_eq("arst_req_addr", imem_req_addr, RESET_PC);
    check_eq("arst_inst", inst, 32'h0);
    check_eq("arst_inst_pc", inst_pc, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    // Randomized traffic.
    fixed_en  = 1'b0;
    delay_min = 0;
    delay_max = 3;
    for (int i = 0; i < 3000; i++) begin
      rpc = $urandom;
      if ($urandom_range(3, 0) == 0) rpc = 32'hFFFF_FFF0 | (rpc & 32'hF);
      step($urandom_range(3, 0) != 0, $urandom_range(2, 0) != 0,
           $urandom_range(15, 0) == 0, rpc, $urandom_range(7, 0) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
